edit_mem_buf_linker: RTL and testbench
======================================

Name: edit_mem_buf_linker

Overview:
- Write-side companion of the edit-memory buffer linked list.
- Accepts a packet as a stream of SIZE-byte chunks. Assigns each chunk a buffer popped from the free-buffer FIFO and returns that pointer so the data can be written.
- Emits the link writes (enq_buf_valid / enq_buf_ptr_cur / enq_buf_ptr_nxt) that build each packet's chain.
- Reports a per-packet completion record (head pointer, tail pointer, buffer count, port id) for descriptor generation.

Parameters:
- BPTR_NBITS, `EM_BUF_PTR_NBITS, buffer pointer width
- ID_NBITS, `PORT_ID_NBITS, port id width
- LEN_NBITS, `PD_CHUNK_DEPTH_NBITS, buffer-count width per packet

Ports:
- clk  in  1  clock
- `RESET_SIG  in  1  reset: synchronous, active-low; the only clock is clk
- wr_valid  in  1  chunk offered
- wr_sop  in  1  first chunk of packet
- wr_eop  in  1  last chunk of packet
- wr_port_id  in  ID_NBITS  port id, sampled on sop
- wr_ready  out  1  chunk accepted when wr_valid&wr_ready
- wr_buf_ptr  out  BPTR_NBITS  buffer assigned to the current chunk (combinational, valid with wr_ready)
- fl_ptr_valid  in  1  free-list FIFO not empty (first-word-fall-through)
- fl_ptr  in  BPTR_NBITS  free-list head
- fl_rd  out  1  pop free list
- enq_buf_valid  out  1  link write
- enq_buf_ptr_cur  out  BPTR_NBITS  buffer being linked
- enq_buf_ptr_nxt  out  BPTR_NBITS  its successor
- pkt_done_valid  out  1  packet record valid
- pkt_head_ptr  out  BPTR_NBITS  first buffer
- pkt_tail_ptr  out  BPTR_NBITS  last buffer
- pkt_nbufs  out  LEN_NBITS  buffer count (saturating)
- pkt_port_id  out  ID_NBITS  port id
- pkt_abort  out  1  packet truncated by an unexpected sop
- err_cnt  out  16  count of dropped orphan chunks, saturating

Behaviour:
- Prefetch register (pf_valid, pf_ptr).
  - fl_rd = fl_ptr_valid & (~pf_valid | accept); on fl_rd, pf_ptr <= fl_ptr and pf_valid <= 1.
  - Otherwise, on accept, pf_valid <= 0.
  - Sustains one chunk per cycle while the free list is non-empty.
- wr_ready = pf_valid; wr_buf_ptr = pf_ptr; accept = wr_valid & wr_ready.
- FSM states IDLE and IN_PKT; reset state is IDLE.
  - IDLE, accept with sop & ~eop: head <= pf_ptr, last <= pf_ptr, nbufs <= 1, port latched, go to IN_PKT.
  - IDLE, accept with sop & eop: single-buffer packet. pkt_done next cycle with head = tail, nbufs = 1, no link write. Stay in IDLE.
  - IDLE, accept with ~sop: orphan chunk. Pointer is consumed (pf refills); err_cnt += 1, saturating at 0xFFFF. No link write and no pkt_done. The buffer is lost; software reclaims it.
  - IN_PKT, accept with ~sop: enq_buf_valid next cycle with cur = last and nxt = pf_ptr. Then last <= pf_ptr and nbufs += 1, saturating at all-ones.
  - IN_PKT, accept with eop (and ~sop): link write as above, plus pkt_done in the same output cycle with tail = pf_ptr. Go to IDLE.
  - IN_PKT, accept with sop (abort): close the open packet. pkt_done next cycle with pkt_abort = 1, tail = last, old nbufs. No link write from last to the new buffer. The new chunk starts a new packet as in the IDLE sop case.
- All outputs are registered with 1-cycle latency from accept. The last buffer of a packet is never linked; the reader is bounded by pd_length.
- Reset values: enq_buf_valid = 0, pkt_done_valid = 0, pkt_abort = 0, err_cnt = 0, pf_valid = 0 (so wr_ready = 0 and fl_rd = 0 in the reset cycle). Data outputs are don't-care until the first valid.
- Reset mid-packet: state returns to IDLE and the partial packet is discarded with no record. Buffers held by the partial packet are lost; pool reinit is required.
- No backpressure on enq or pkt_done outputs. Downstream must accept one of each per cycle.

Decomposition:
- Shared package: FSM state encoding (IDLE = 0, IN_PKT = 1) and the pkt-record field layout {port_id, nbufs, tail, head} for the descriptor FIFO.
- One natural sub-module: em_ptr_prefetch, containing the pf register and fl_rd logic, reusable by other free-list consumers.

Test Plan:
- Free list preloaded with 10, 11, 12; 3-chunk packet (sop, -, eop) back-to-back, port 5 -> wr_buf_ptr 10, 11, 12. Links (10→11) and (11→12) one cycle after chunks 2 and 3. pkt_done head = 10, tail = 12, nbufs = 3, port = 5, abort = 0.
- Single-chunk sop & eop with ptr 20 -> no enq_buf_valid; pkt_done head = tail = 20, nbufs = 1.
- Free list empties after ptr 30 during a 2-chunk packet -> wr_ready low until fl_ptr_valid. On refill with ptr 31, link (30→31) and pkt_done tail = 31.
- sop (ptr 40), chunk (41), then sop (42) -> link (40→41); pkt_done abort = 1, head = 40, tail = 41, nbufs = 2. New packet head = 42 with no 41→42 link.
- ~sop chunk while IDLE -> err_cnt 0→1, no link, no pkt_done, fl_rd pops one pointer.
- Assert reset mid-packet after 2 chunks -> next cycle enq_buf_valid = 0, pkt_done_valid = 0, wr_ready = 0. A following sop starts a clean packet with nbufs = 1.

Source files
------------

// File: rtl/edit_mem_buf_linker_pkg.sv
// Shared definitions for the edit-memory buffer linker.
//   - Default widths for buffer pointers, port ids and per-packet buffer counts.
//   - Link FSM state encoding.
//   - Packet completion record layout {port_id, nbufs, tail, head} used by the
//     descriptor FIFO that consumes the linker's pkt_done stream.
package edit_mem_buf_linker_pkg;

  localparam int EM_BUF_PTR_NBITS     = 10;
  localparam int PORT_ID_NBITS        = 4;
  localparam int PD_CHUNK_DEPTH_NBITS = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } link_state_e;

  // Descriptor FIFO word, head in the least significant bits.
  typedef struct packed {
    logic [PORT_ID_NBITS-1:0]        port_id;
    logic [PD_CHUNK_DEPTH_NBITS-1:0] nbufs;
    logic [EM_BUF_PTR_NBITS-1:0]     tail;
    logic [EM_BUF_PTR_NBITS-1:0]     head;
  } pkt_rec_t;

  // Record width for non-default parameterisations of the linker.
  function automatic int pkt_rec_nbits(int bptr_nbits, int len_nbits, int id_nbits);
    return id_nbits + len_nbits + 2 * bptr_nbits;
  endfunction

endpackage

// File: rtl/em_ptr_prefetch.sv
// Free-list pointer prefetch register.
// Holds one pointer popped from a first-word-fall-through free-list FIFO so a
// consumer can take a pointer every cycle while the free list is non-empty.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   fl_ptr_valid   free list not empty
//   fl_ptr         free-list head
//   fl_rd          pop free list
//   take           consumer takes pf_ptr this cycle (only meaningful with pf_valid)
//   pf_valid       a prefetched pointer is available
//   pf_ptr         the prefetched pointer
module em_ptr_prefetch
  import edit_mem_buf_linker_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fl_ptr_valid,
  input  logic [BPTR_NBITS-1:0] fl_ptr,
  output logic                  fl_rd,
  input  logic                  take,
  output logic                  pf_valid,
  output logic [BPTR_NBITS-1:0] pf_ptr
);

  logic                  pf_valid_q, pf_valid_d;
  logic [BPTR_NBITS-1:0] pf_ptr_q, pf_ptr_d;

  always_comb begin
    // Never pop while in reset: the popped pointer would be lost when the
    // register clears.
    fl_rd      = rst_n & fl_ptr_valid & (~pf_valid_q | take);
    pf_valid_d = pf_valid_q;
    pf_ptr_d   = pf_ptr_q;
    if (fl_rd) begin
      pf_valid_d = 1'b1;
      pf_ptr_d   = fl_ptr;
    end else if (take) begin
      pf_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) pf_valid_q <= 1'b0;
    else        pf_valid_q <= pf_valid_d;
  end

  // NOTE: pure datapath registers carry no reset; they are qualified by a
  // valid flag, and leaving them unreset keeps the reset tree small.
  always_ff @(posedge clk) begin
    pf_ptr_q <= pf_ptr_d;
  end

  assign pf_valid = pf_valid_q;
  assign pf_ptr   = pf_ptr_q;

endmodule

// File: rtl/edit_mem_buf_linker.sv
// Write-side linker for the edit-memory buffer linked list.
// Assigns a free buffer to each incoming chunk, emits link writes chaining the
// buffers of a packet, and reports one completion record per packet.
// All outputs except wr_ready/wr_buf_ptr/fl_rd are registered, one cycle after
// the accepting clock edge.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wr_valid/sop/eop/port_id        chunk stream in; wr_ready/wr_buf_ptr out
//   fl_ptr_valid/fl_ptr/fl_rd       free-list FIFO (first-word-fall-through)
//   enq_buf_valid/ptr_cur/ptr_nxt   link write cur -> nxt
//   pkt_done_valid/head/tail/nbufs/port_id/abort   packet record
//   err_cnt                         saturating count of orphan chunks dropped
module edit_mem_buf_linker
  import edit_mem_buf_linker_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int ID_NBITS   = PORT_ID_NBITS,
  parameter int LEN_NBITS  = PD_CHUNK_DEPTH_NBITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic [ID_NBITS-1:0]   wr_port_id,
  output logic                  wr_ready,
  output logic [BPTR_NBITS-1:0] wr_buf_ptr,
  input  logic                  fl_ptr_valid,
  input  logic [BPTR_NBITS-1:0] fl_ptr,
  output logic                  fl_rd,
  output logic                  enq_buf_valid,
  output logic [BPTR_NBITS-1:0] enq_buf_ptr_cur,
  output logic [BPTR_NBITS-1:0] enq_buf_ptr_nxt,
  output logic                  pkt_done_valid,
  output logic [BPTR_NBITS-1:0] pkt_head_ptr,
  output logic [BPTR_NBITS-1:0] pkt_tail_ptr,
  output logic [LEN_NBITS-1:0]  pkt_nbufs,
  output logic [ID_NBITS-1:0]   pkt_port_id,
  output logic                  pkt_abort,
  output logic [15:0]           err_cnt
);

  localparam logic [LEN_NBITS-1:0] NBUFS_ONE = LEN_NBITS'(1);

  logic                  pf_valid, accept;
  logic [BPTR_NBITS-1:0] pf_ptr;

  em_ptr_prefetch #(.BPTR_NBITS(BPTR_NBITS)) u_prefetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .fl_ptr_valid (fl_ptr_valid),
    .fl_ptr       (fl_ptr),
    .fl_rd        (fl_rd),
    .take         (accept),
    .pf_valid     (pf_valid),
    .pf_ptr       (pf_ptr)
  );

  assign wr_ready   = pf_valid;
  assign wr_buf_ptr = pf_ptr;
  assign accept     = wr_valid & pf_valid;

  // Open-packet context.
  link_state_e           state_q, state_d;
  logic [BPTR_NBITS-1:0] head_q, head_d, last_q, last_d;
  logic [LEN_NBITS-1:0]  nbufs_q, nbufs_d, nbufs_inc;
  logic [ID_NBITS-1:0]   port_q, port_d;
  logic [15:0]           err_cnt_q, err_cnt_d, err_cnt_inc;

  // Registered outputs.
  logic                  enq_valid_q, enq_valid_d;
  logic [BPTR_NBITS-1:0] enq_cur_q, enq_cur_d, enq_nxt_q, enq_nxt_d;
  logic                  done_valid_q, done_valid_d, abort_q, abort_d;
  logic [BPTR_NBITS-1:0] done_head_q, done_head_d, done_tail_q, done_tail_d;
  logic [LEN_NBITS-1:0]  done_nbufs_q, done_nbufs_d;
  logic [ID_NBITS-1:0]   done_port_q, done_port_d;
  logic                  start_pkt;

  assign nbufs_inc   = (&nbufs_q) ? nbufs_q : nbufs_q + NBUFS_ONE;
  assign err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 16'd1;

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    last_d       = last_q;
    nbufs_d      = nbufs_q;
    port_d       = port_q;
    err_cnt_d    = err_cnt_q;
    enq_valid_d  = 1'b0;
    enq_cur_d    = enq_cur_q;
    enq_nxt_d    = enq_nxt_q;
    done_valid_d = 1'b0;
    abort_d      = 1'b0;
    done_head_d  = done_head_q;
    done_tail_d  = done_tail_q;
    done_nbufs_d = done_nbufs_q;
    done_port_d  = done_port_q;
    start_pkt    = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (wr_sop && wr_eop) begin
            done_valid_d = 1'b1;
            done_head_d  = pf_ptr;
            done_tail_d  = pf_ptr;
            done_nbufs_d = NBUFS_ONE;
            done_port_d  = wr_port_id;
          end else if (wr_sop) begin
            start_pkt = 1'b1;
          end else begin
            // Orphan chunk: its buffer is consumed and left for software.
            err_cnt_d = err_cnt_inc;
          end
        end
        IN_PKT: begin
          if (wr_sop) begin
            // Close the truncated packet; the new buffer is not chained to it.
            done_valid_d = 1'b1;
            abort_d      = 1'b1;
            done_head_d  = head_q;
            done_tail_d  = last_q;
            done_nbufs_d = nbufs_q;
            done_port_d  = port_q;
            if (wr_eop) begin
              // The record slot is taken by the abort, so a single-buffer
              // packet arriving here is dropped like an orphan.
              state_d   = IDLE;
              err_cnt_d = err_cnt_inc;
            end else begin
              start_pkt = 1'b1;
            end
          end else begin
            enq_valid_d = 1'b1;
            enq_cur_d   = last_q;
            enq_nxt_d   = pf_ptr;
            last_d      = pf_ptr;
            nbufs_d     = nbufs_inc;
            if (wr_eop) begin
              done_valid_d = 1'b1;
              done_head_d  = head_q;
              done_tail_d  = pf_ptr;
              done_nbufs_d = nbufs_inc;
              done_port_d  = port_q;
              state_d      = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_pkt) begin
      state_d = IN_PKT;
      head_d  = pf_ptr;
      last_d  = pf_ptr;
      nbufs_d = NBUFS_ONE;
      port_d  = wr_port_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      err_cnt_q    <= '0;
      enq_valid_q  <= 1'b0;
      done_valid_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_cnt_q    <= err_cnt_d;
      enq_valid_q  <= enq_valid_d;
      done_valid_q <= done_valid_d;
      abort_q      <= abort_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q       <= head_d;
    last_q       <= last_d;
    nbufs_q      <= nbufs_d;
    port_q       <= port_d;
    enq_cur_q    <= enq_cur_d;
    enq_nxt_q    <= enq_nxt_d;
    done_head_q  <= done_head_d;
    done_tail_q  <= done_tail_d;
    done_nbufs_q <= done_nbufs_d;
    done_port_q  <= done_port_d;
  end

  assign enq_buf_valid   = enq_valid_q;
  assign enq_buf_ptr_cur = enq_cur_q;
  assign enq_buf_ptr_nxt = enq_nxt_q;
  assign pkt_done_valid  = done_valid_q;
  assign pkt_head_ptr    = done_head_q;
  assign pkt_tail_ptr    = done_tail_q;
  assign pkt_nbufs       = done_nbufs_q;
  assign pkt_port_id     = done_port_q;
  assign pkt_abort       = abort_q;
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_edit_mem_buf_linker.sv
// Self-checking bench for edit_mem_buf_linker: a free-list queue feeds the DUT,
// a small reference model predicts handshakes, link writes and packet records,
// and a scoreboard compares them one cycle after each accepted chunk.
module tb_edit_mem_buf_linker;

  localparam int BP  = 10;
  localparam int ID  = 4;
  localparam int LEN = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0;
  logic [ID-1:0] wr_port_id = '0;
  logic          wr_ready;
  logic [BP-1:0] wr_buf_ptr;
  logic          fl_ptr_valid = 1'b0;
  logic [BP-1:0] fl_ptr = '0;
  logic          fl_rd;
  logic          enq_buf_valid;
  logic [BP-1:0] enq_buf_ptr_cur, enq_buf_ptr_nxt;
  logic          pkt_done_valid;
  logic [BP-1:0] pkt_head_ptr, pkt_tail_ptr;
  logic [LEN-1:0] pkt_nbufs;
  logic [ID-1:0] pkt_port_id;
  logic          pkt_abort;
  logic [15:0]   err_cnt;

  edit_mem_buf_linker #(.BPTR_NBITS(BP), .ID_NBITS(ID), .LEN_NBITS(LEN)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_sop          (wr_sop),
    .wr_eop          (wr_eop),
    .wr_port_id      (wr_port_id),
    .wr_ready        (wr_ready),
    .wr_buf_ptr      (wr_buf_ptr),
    .fl_ptr_valid    (fl_ptr_valid),
    .fl_ptr          (fl_ptr),
    .fl_rd           (fl_rd),
    .enq_buf_valid   (enq_buf_valid),
    .enq_buf_ptr_cur (enq_buf_ptr_cur),
    .enq_buf_ptr_nxt (enq_buf_ptr_nxt),
    .pkt_done_valid  (pkt_done_valid),
    .pkt_head_ptr    (pkt_head_ptr),
    .pkt_tail_ptr    (pkt_tail_ptr),
    .pkt_nbufs       (pkt_nbufs),
    .pkt_port_id     (pkt_port_id),
    .pkt_abort       (pkt_abort),
    .err_cnt         (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [ID-1:0] port;
    logic [BP-1:0] ptr;
  } vec_t;

  typedef struct {
    logic [BP-1:0] cur;
    logic [BP-1:0] nxt;
  } enq_t;

  typedef struct {
    logic [BP-1:0]  head;
    logic [BP-1:0]  tail;
    logic [LEN-1:0] nbufs;
    logic [ID-1:0]  port;
    logic           abort;
  } done_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BP-1:0] fl_q[$];
  enq_t          exp_enq[$];
  done_t         exp_done[$];

  // Reference model state.
  bit             m_pf_valid = 1'b0;
  logic [BP-1:0]  m_pf_ptr = '0;
  bit             m_in_pkt = 1'b0;
  logic [BP-1:0]  m_head = '0, m_last = '0;
  logic [LEN-1:0] m_nbufs = '0;
  logic [ID-1:0]  m_port = '0;
  int             m_err = 0;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LEN-1:0] sat_inc(input logic [LEN-1:0] v);
    return (v == {LEN{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_accept(input logic [BP-1:0] ptr);
    done_t d;
    if (!m_in_pkt) begin
      if (wr_sop && wr_eop) begin
        d = '{head: ptr, tail: ptr, nbufs: 1, port: wr_port_id, abort: 1'b0};
        exp_done.push_back(d);
      end else if (wr_sop) begin
        m_in_pkt = 1'b1; m_head = ptr; m_last = ptr; m_nbufs = 1; m_port = wr_port_id;
      end else begin
        m_err = (m_err == 65535) ? m_err : m_err + 1;
      end
    end else if (wr_sop) begin
      d = '{head: m_head, tail: m_last, nbufs: m_nbufs, port: m_port, abort: 1'b1};
      exp_done.push_back(d);
      if (wr_eop) begin
        m_in_pkt = 1'b0;
        m_err = (m_err == 65535) ? m_err : m_err + 1;
      end else begin
        m_head = ptr; m_last = ptr; m_nbufs = 1; m_port = wr_port_id;
      end
    end else begin
      exp_enq.push_back('{cur: m_last, nxt: ptr});
      m_last  = ptr;
      m_nbufs = sat_inc(m_nbufs);
      if (wr_eop) begin
        d = '{head: m_head, tail: ptr, nbufs: m_nbufs, port: m_port, abort: 1'b0};
        exp_done.push_back(d);
        m_in_pkt = 1'b0;
      end
    end
  endtask

  task automatic drive_fl();
    fl_ptr_valid = (fl_q.size() > 0);
    fl_ptr       = (fl_q.size() > 0) ? fl_q[0] : '0;
  endtask

  // One clock cycle, entered and left at a falling edge with inputs applied.
  task automatic tick(input bit chk_tbl = 1'b0, input logic [BP-1:0] tbl_ptr = '0);
    bit   acc, rd;
    enq_t e;
    done_t d;
    drive_fl();
    #1;
    check("wr_ready", wr_ready, m_pf_valid);
    acc = wr_valid && m_pf_valid;
    rd  = fl_ptr_valid && (!m_pf_valid || acc);
    check("fl_rd", fl_rd, rd);
    if (acc) begin
      check("wr_buf_ptr", wr_buf_ptr, m_pf_ptr);
      if (chk_tbl) check("tbl_ptr", wr_buf_ptr, tbl_ptr);
      model_accept(m_pf_ptr);
    end
    if (rd) begin
      m_pf_valid = 1'b1;
      m_pf_ptr   = fl_ptr;
    end else if (acc) begin
      m_pf_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rd) void'(fl_q.pop_front());
    check("enq_valid", enq_buf_valid, exp_enq.size() > 0);
    if (exp_enq.size() > 0) begin
      e = exp_enq.pop_front();
      if (enq_buf_valid) begin
        check("enq_cur", enq_buf_ptr_cur, e.cur);
        check("enq_nxt", enq_buf_ptr_nxt, e.nxt);
      end
    end
    check("done_valid", pkt_done_valid, exp_done.size() > 0);
    if (exp_done.size() > 0) begin
      d = exp_done.pop_front();
      if (pkt_done_valid) begin
        check("done_head", pkt_head_ptr, d.head);
        check("done_tail", pkt_tail_ptr, d.tail);
        check("done_nbufs", pkt_nbufs, d.nbufs);
        check("done_port", pkt_port_id, d.port);
        check("done_abort", pkt_abort, d.abort);
      end
    end
    check("err_cnt", err_cnt, m_err);
    @(negedge clk);
  endtask

  task automatic chunk(input bit sop, input bit eop, input logic [ID-1:0] port);
    wr_valid = 1'b1; wr_sop = sop; wr_eop = eop; wr_port_id = port;
    tick();
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    drive_fl();
    #1;
    check("rst_fl_rd_pre", fl_rd, 1'b0);
    @(posedge clk);
    #1;
    check("rst_enq_valid", enq_buf_valid, 1'b0);
    check("rst_done_valid", pkt_done_valid, 1'b0);
    check("rst_abort", pkt_abort, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_fl_rd", fl_rd, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    m_pf_valid = 1'b0; m_in_pkt = 1'b0; m_err = 0;
    exp_enq.delete(); exp_done.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{sop: 1'b1, eop: 1'b0, port: 4'd5, ptr: 10'd10};
    vecs[1] = '{sop: 1'b0, eop: 1'b0, port: 4'd5, ptr: 10'd11};
    vecs[2] = '{sop: 1'b0, eop: 1'b1, port: 4'd5, ptr: 10'd12};
    vecs[3] = '{sop: 1'b1, eop: 1'b1, port: 4'd3, ptr: 10'd20};

    @(negedge clk);
    do_reset();

    // 3-chunk packet then a single-chunk packet, back to back.
    fl_q = '{10'd10, 10'd11, 10'd12, 10'd20};
    idle(1);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_sop = vecs[i].sop; wr_eop = vecs[i].eop;
      wr_port_id = vecs[i].port;
      tick(1'b1, vecs[i].ptr);
    end
    idle(2);

    // Free list runs dry mid-packet, then refills.
    fl_q.push_back(10'd30);
    idle(1);
    chunk(1'b1, 1'b0, 4'd2);
    wr_valid = 1'b1; wr_sop = 1'b0; wr_eop = 1'b1;
    tick(); tick(); tick();
    fl_q.push_back(10'd31);
    tick();
    tick(1'b1, 10'd31);
    idle(2);

    // Unexpected sop aborts the open packet; the new packet has no back-link.
    fl_q = '{10'd40, 10'd41, 10'd42, 10'd43};
    idle(1);
    chunk(1'b1, 1'b0, 4'd7);
    chunk(1'b0, 1'b0, 4'd7);
    chunk(1'b1, 1'b0, 4'd9);
    chunk(1'b0, 1'b1, 4'd9);
    idle(2);

    // Orphan chunk while idle.
    fl_q.push_back(10'd50);
    idle(1);
    chunk(1'b0, 1'b0, 4'd1);
    idle(2);
    check("orphan_err", err_cnt, 16'd1);

    // Reset in the middle of a packet, then a clean single-buffer packet.
    fl_q = '{10'd60, 10'd61, 10'd62};
    idle(1);
    chunk(1'b1, 1'b0, 4'd4);
    chunk(1'b0, 1'b0, 4'd4);
    do_reset();
    fl_q = '{10'd70};
    idle(1);
    chunk(1'b1, 1'b1, 4'd6);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
